// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the two-port data-RAM arbiter:
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD; 2'b11 behaves as word)
//   - FSM state encoding (S_IDLE, S_RD, S_RMW_RD, S_WR, S_RESP)
//   - size_nbytes(): number of RAM bytes touched by an access of a given size
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef logic [1:0] size_t;

    localparam size_t SZ_BYTE = 2'b00;
    localparam size_t SZ_HALF = 2'b01;
    localparam size_t SZ_WORD = 2'b10;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD     = 3'd1;
    localparam logic [2:0] S_RMW_RD = 3'd2;
    localparam logic [2:0] S_WR     = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    // Size 2'b11 is not a legal encoding from the requesters; it is folded
    // into word so every input pattern maps to a defined access.
    function automatic logic [2:0] size_nbytes(input size_t size);
        case (size)
            SZ_BYTE: size_nbytes = 3'd1;
            SZ_HALF: size_nbytes = 3'd2;
            default: size_nbytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the two requester ports and the RAM-side bus of mem_arbiter.
//   Requester port n (n = 0 CPU load/store, n = 1 DMA/loader):
//     rqn_req, rqn_we, rqn_size, rqn_uns, rqn_addr, rqn_wdata  -> arbiter
//     rqn_ack, rqn_err                                          <- arbiter
//   Shared load result: rdata (valid in the ack cycle)           <- arbiter
//   RAM bus: mem_address, mem_data_in, mem_MemRead, mem_MemWrite <- arbiter
//            mem_data_out                                        -> arbiter
// Modports:
//   master : the requesters plus the RAM (the environment around the arbiter)
//   slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
) ();

    logic              rq0_req;
    logic              rq0_we;
    logic [1:0]        rq0_size;
    logic              rq0_uns;
    logic [ADDR_W-1:0] rq0_addr;
    logic [31:0]       rq0_wdata;
    logic              rq0_ack;
    logic              rq0_err;

    logic              rq1_req;
    logic              rq1_we;
    logic [1:0]        rq1_size;
    logic              rq1_uns;
    logic [ADDR_W-1:0] rq1_addr;
    logic [31:0]       rq1_wdata;
    logic              rq1_ack;
    logic              rq1_err;

    logic [31:0]       rdata;

    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_data_in;
    logic              mem_MemRead;
    logic              mem_MemWrite;
    logic [31:0]       mem_data_out;

    modport master (
        output rq0_req, rq0_we, rq0_size, rq0_uns, rq0_addr, rq0_wdata,
        output rq1_req, rq1_we, rq1_size, rq1_uns, rq1_addr, rq1_wdata,
        input  rq0_ack, rq0_err, rq1_ack, rq1_err, rdata,
        input  mem_address, mem_data_in, mem_MemRead, mem_MemWrite,
        output mem_data_out
    );

    modport slave (
        input  rq0_req, rq0_we, rq0_size, rq0_uns, rq0_addr, rq0_wdata,
        input  rq1_req, rq1_we, rq1_size, rq1_uns, rq1_addr, rq1_wdata,
        output rq0_ack, rq0_err, rq1_ack, rq1_err, rdata,
        output mem_address, mem_data_in, mem_MemRead, mem_MemWrite,
        input  mem_data_out
    );

endinterface

// File: rtl/mem_arbiter_lane.sv
// -----------------------------------------------------------------------------
// mem_arbiter_lane
// Purely combinational byte-lane logic for sub-word accesses.
//   size_i     access size (byte / half / word, 2'b11 = word)
//   uns_i      1 = zero-extend loads, 0 = sign-extend
//   old_i      word currently in RAM (read phase of a read-modify-write)
//   wdata_i    store data, low-aligned
//   raw_i      raw word read from RAM for a load
//   merged_o   old_i with the low nbytes replaced by wdata_i
//   loaded_o   raw_i truncated to the access size and extended to 32 bits
// -----------------------------------------------------------------------------
module mem_arbiter_lane
    import mem_arbiter_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [31:0] old_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] raw_i,
    output logic [31:0] merged_o,
    output logic [31:0] loaded_o
);

    logic [2:0] nbytes;
    assign nbytes = size_nbytes(size_i);

    // Byte lane gi carries new data when it lies inside the access,
    // otherwise it keeps the value already in RAM.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge
            localparam logic [2:0] LANE = 3'(gi);
            assign merged_o[8*gi +: 8] = (LANE < nbytes) ? wdata_i[8*gi +: 8]
                                                         : old_i[8*gi +: 8];
        end
    endgenerate

    logic sign_byte;
    logic sign_half;
    assign sign_byte = ~uns_i & raw_i[7];
    assign sign_half = ~uns_i & raw_i[15];

    always_comb begin
        case (size_i)
            SZ_BYTE: loaded_o = {{24{sign_byte}}, raw_i[7:0]};
            SZ_HALF: loaded_o = {{16{sign_half}}, raw_i[15:0]};
            default: loaded_o = raw_i;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port, byte-addressed, little-endian data RAM between the
// CPU load/store port (port 0) and the DMA/program-loader port (port 1).
// Round-robin arbitration on ties, one transaction at a time, byte/half/word
// accesses; sub-word stores are done as read-modify-write because the RAM
// always writes four bytes.
//
// Ports:
//   Clk    rising-edge clock
//   Reset  asynchronous, active-high reset
//   bus    mem_arbiter_if.slave: both requester ports, rdata and the RAM bus
//
// Parameters:
//   MEM_BYTES  RAM size; an access with addr + nbytes > MEM_BYTES is rejected
//   ADDR_W     address width (must match the interface instance)
//
// Build option:
//   MEM_ARBITER_ALIGN_CHECK_EN  when defined, misaligned half/word accesses
//                               are rejected like out-of-range accesses.
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_BYTES = 64,
    parameter int ADDR_W    = 32
) (
    input  logic         Clk,
    input  logic         Reset,
    mem_arbiter_if.slave bus
);

    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_BYTES);

    // ---------------------------------------------------------------- state
    logic [2:0]        state_q,  state_d;
    logic              rr_q,     rr_d;     // port granted at the last tie
    logic              id_q,     id_d;
    logic              we_q,     we_d;
    logic [1:0]        size_q,   size_d;
    logic              uns_q,    uns_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [31:0]       wdata_q,  wdata_d;
    logic [31:0]       data_q,   data_d;   // raw load word or merged store word
    logic              err_q,    err_d;

    // ------------------------------------------------------ request select
    logic              both_req;
    logic              any_req;
    logic              pick_id;
    logic              sel_we;
    logic [1:0]        sel_size;
    logic              sel_uns;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;

    assign both_req = bus.rq0_req & bus.rq1_req;
    assign any_req  = bus.rq0_req | bus.rq1_req;

    // On a tie the port that did not win the previous tie is served.
    always_comb begin
        if (both_req) begin
            pick_id = ~rr_q;
        end else begin
            pick_id = bus.rq1_req;
        end
    end

    assign sel_we    = pick_id ? bus.rq1_we    : bus.rq0_we;
    assign sel_size  = pick_id ? bus.rq1_size  : bus.rq0_size;
    assign sel_uns   = pick_id ? bus.rq1_uns   : bus.rq0_uns;
    assign sel_addr  = pick_id ? bus.rq1_addr  : bus.rq0_addr;
    assign sel_wdata = pick_id ? bus.rq1_wdata : bus.rq0_wdata;

    // ------------------------------------------------------- reject checks
    logic [2:0]      sel_nbytes;
    logic [ADDR_W:0] sel_end;
    logic            out_of_range;
    logic            misalign;
    logic            reject;
    logic            sel_is_word;

    assign sel_nbytes   = size_nbytes(sel_size);
    assign sel_is_word  = sel_size[1];
    // One extra bit keeps addresses near the top of the space from wrapping.
    assign sel_end      = {1'b0, sel_addr} + {{(ADDR_W-2){1'b0}}, sel_nbytes};
    assign out_of_range = sel_end > MEM_LIMIT;

`ifdef MEM_ARBITER_ALIGN_CHECK_EN
    assign misalign = ((sel_size == SZ_HALF) && sel_addr[0]) ||
                      (sel_is_word && (sel_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign reject = out_of_range | misalign;

    // ------------------------------------------------------------ byte lanes
    logic [31:0] lane_merged;
    logic [31:0] lane_loaded;

    mem_arbiter_lane u_lane (
        .size_i   (size_q),
        .uns_i    (uns_q),
        .old_i    (bus.mem_data_out),
        .wdata_i  (wdata_q),
        .raw_i    (data_q),
        .merged_o (lane_merged),
        .loaded_o (lane_loaded)
    );

    // ------------------------------------------------------------ next state
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    id_d    = pick_id;
                    we_d    = sel_we;
                    size_d  = sel_size;
                    uns_d   = sel_uns;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    err_d   = reject;
                    if (both_req) begin
                        rr_d = pick_id;
                    end
                    if (reject) begin
                        state_d = S_RESP;
                    end else if (!sel_we) begin
                        state_d = S_RD;
                    end else if (sel_is_word) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_RD: begin
                data_d  = bus.mem_data_out;
                state_d = S_RESP;
            end
            S_RMW_RD: begin
                data_d  = lane_merged;
                state_d = S_WR;
            end
            S_WR: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            rr_q    <= 1'b1;
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // --------------------------------------------------------------- outputs
    // Outputs decode straight from state_q so an asynchronous reset drops
    // MemWrite (and everything else) without waiting for a clock edge.
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_data_in;
    logic              mem_read;
    logic              mem_write;
    logic              ack0;
    logic              ack1;
    logic              err0;
    logic              err1;
    logic [31:0]       rdata;

    always_comb begin
        mem_address = '0;
        mem_data_in = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ack0        = 1'b0;
        ack1        = 1'b0;
        err0        = 1'b0;
        err1        = 1'b0;
        rdata       = '0;

        case (state_q)
            S_RD, S_RMW_RD: begin
                mem_read    = 1'b1;
                mem_address = addr_q;
            end
            S_WR: begin
                mem_write   = 1'b1;
                mem_address = addr_q;
                mem_data_in = size_q[1] ? wdata_q : data_q;
            end
            S_RESP: begin
                ack0  = ~id_q;
                ack1  = id_q;
                err0  = ~id_q & err_q;
                err1  = id_q & err_q;
                rdata = (we_q || err_q) ? 32'h0 : lane_loaded;
            end
            default: begin
            end
        endcase
    end

    assign bus.mem_address  = mem_address;
    assign bus.mem_data_in  = mem_data_in;
    assign bus.mem_MemRead  = mem_read;
    assign bus.mem_MemWrite = mem_write;
    assign bus.rq0_ack      = ack0;
    assign bus.rq1_ack      = ack1;
    assign bus.rq0_err      = err0;
    assign bus.rq1_err      = err1;
    assign bus.rdata        = rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Drives both requester ports of mem_arbiter, models the 64-byte RAM, and
// compares every response against a byte-array reference model of memory.
// Build option MEM_ARBITER_ALIGN_CHECK_EN changes the unaligned expectations.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int MEMB = 64;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;

    mem_arbiter_if #(.ADDR_W(32)) bus ();

    mem_arbiter #(.MEM_BYTES(MEMB), .ADDR_W(32)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------ RAM model
    logic [7:0] ram [MEMB] = '{default: 8'h00};

    always_comb begin
        longint a;
        a = longint'({32'h0, bus.mem_address});
        bus.mem_data_out = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (a + k < MEMB) bus.mem_data_out[8*k +: 8] = ram[a + k];
        end
    end

    always @(posedge Clk) begin
        longint wa;
        wa = longint'({32'h0, bus.mem_address});
        if (bus.mem_MemWrite) begin
            for (int k = 0; k < 4; k++) begin
                if (wa + k < MEMB) ram[wa + k] <= bus.mem_data_in[8*k +: 8];
            end
        end
    end

    // ------------------------------------------------------ reference model
    logic [7:0] ref_mem [MEMB];

    function automatic int nbytes_of(input logic [1:0] s);
        if (s == 2'd0) return 1;
        if (s == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic exp_reject(input logic [31:0] addr, input logic [1:0] s);
        int n;
        logic r;
        n = nbytes_of(s);
        r = (longint'({32'h0, addr}) + n) > MEMB;
`ifdef MEM_ARBITER_ALIGN_CHECK_EN
        if ((addr % n) != 0) r = 1'b1;
`endif
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] addr, input logic [1:0] s, input logic uns);
        int n;
        longint v;
        n = nbytes_of(s);
        v = 0;
        for (int k = 0; k < n; k++) v += longint'(ref_mem[addr + k]) << (8 * k);
        if (!uns && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    // Word the RAM should see on a store: low nbytes from wdata, the rest is
    // whatever the RAM already holds (zero beyond the end of the array).
    function automatic logic [31:0] exp_wword(input logic [31:0] addr, input logic [1:0] s, input logic [31:0] wdata);
        logic [31:0] w;
        int n;
        n = nbytes_of(s);
        for (int k = 0; k < 4; k++) begin
            if (k < n) w[8*k +: 8] = wdata[8*k +: 8];
            else if (addr + k < MEMB) w[8*k +: 8] = ref_mem[addr + k];
            else w[8*k +: 8] = 8'h00;
        end
        return w;
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [1:0] s, input logic [31:0] wdata);
        for (int k = 0; k < nbytes_of(s); k++) ref_mem[addr + k] = wdata[8*k +: 8];
    endtask

    // --------------------------------------------------------------- driver
    task automatic drive(input int port, input logic req, input logic we, input logic [1:0] s,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            bus.rq0_req = req; bus.rq0_we = we; bus.rq0_size = s;
            bus.rq0_uns = uns; bus.rq0_addr = addr; bus.rq0_wdata = wdata;
        end else begin
            bus.rq1_req = req; bus.rq1_we = we; bus.rq1_size = s;
            bus.rq1_uns = uns; bus.rq1_addr = addr; bus.rq1_wdata = wdata;
        end
    endtask

    // Runs one single-port transaction from IDLE and reports what was seen.
    // lat counts cycles from the acceptance edge to the ack cycle (-1 = none).
    task automatic run_txn(input int port, input logic we, input logic [1:0] s, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output logic [31:0] rd, output logic er,
                           output int nrd, output int nwr, output logic [31:0] wd, output int stray);
        lat = -1; rd = 32'h0; er = 1'b0; nrd = 0; nwr = 0; wd = 32'h0; stray = 0;
        @(negedge Clk);
        drive(port, 1'b1, we, s, uns, addr, wdata);
        for (int c = 1; c <= 20; c++) begin
            @(negedge Clk);
            if (bus.mem_MemRead) nrd++;
            if (bus.mem_MemWrite) begin nwr++; wd = bus.mem_data_in; end
            if ((port == 0) ? bus.rq1_ack : bus.rq0_ack) stray++;
            if ((port == 0) ? bus.rq0_ack : bus.rq1_ack) begin
                lat = c;
                rd  = bus.rdata;
                er  = (port == 0) ? bus.rq0_err : bus.rq1_err;
                break;
            end
        end
        drive(port, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        @(negedge Clk);
        $display("txn p%0d we=%0b sz=%0d uns=%0b addr=%0d wdata=%h -> lat=%0d rdata=%h err=%0b rd=%0d wr=%0d",
                 port, we, s, uns, addr, wdata, lat, rd, er, nrd, nwr);
    endtask

    function automatic logic [79:0] all_outs();
        return {bus.rq0_ack, bus.rq1_ack, bus.rq0_err, bus.rq1_err, bus.mem_MemRead,
                bus.mem_MemWrite, bus.rdata, bus.mem_address[13:0], bus.mem_data_in[25:0]} |
               {46'h0, bus.mem_address[31:14] != 18'h0, 32'h0, bus.mem_data_in[31:26] != 6'h0};
    endfunction

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        Reset = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        checks++;
        if (all_outs() !== 80'h0) begin errors++; $display("FAIL reset_outputs got %h want 0", all_outs()); end
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if (all_outs() !== 80'h0) begin errors++; $display("FAIL idle_outputs got %h want 0", all_outs()); end
    endtask

    task automatic test_word_store_load();
        int lat, nrd, nwr, stray; logic [31:0] rd, wd; logic er;
        run_txn(0, 1'b1, SZ_WORD, 1'b0, 32'd8, 32'hDEADBEEF, lat, rd, er, nrd, nwr, wd, stray);
        ref_store(32'd8, SZ_WORD, 32'hDEADBEEF);
        checks++; if (lat !== 2) begin errors++; $display("FAIL wstore_lat got %0d want 2", lat); end
        checks++; if (nwr !== 1 || nrd !== 0) begin errors++; $display("FAIL wstore_strobes got rd=%0d wr=%0d want 0/1", nrd, nwr); end
        checks++; if (wd !== 32'hDEADBEEF) begin errors++; $display("FAIL wstore_data got %h want deadbeef", wd); end
        run_txn(0, 1'b0, SZ_WORD, 1'b0, 32'd8, 32'h0, lat, rd, er, nrd, nwr, wd, stray);
        checks++; if (lat !== 2) begin errors++; $display("FAIL wload_lat got %0d want 2", lat); end
        checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL wload_data got %h err=%0b want deadbeef", rd, er); end
        checks++; if (stray !== 0) begin errors++; $display("FAIL wload_stray got %0d want 0", stray); end
    endtask

    task automatic test_subword();
        int lat, nrd, nwr, stray; logic [31:0] rd, wd; logic er;
        run_txn(1, 1'b1, SZ_BYTE, 1'b0, 32'd8, 32'h1234565A, lat, rd, er, nrd, nwr, wd, stray);
        ref_store(32'd8, SZ_BYTE, 32'h1234565A);
        checks++; if (lat !== 3) begin errors++; $display("FAIL bstore_lat got %0d want 3", lat); end
        checks++; if (nrd !== 1 || nwr !== 1) begin errors++; $display("FAIL bstore_strobes got rd=%0d wr=%0d want 1/1", nrd, nwr); end
        checks++; if (wd !== 32'hDEADBE5A) begin errors++; $display("FAIL bstore_merge got %h want deadbe5a", wd); end
        run_txn(0, 1'b0, SZ_BYTE, 1'b0, 32'd8, 32'h0, lat, rd, er, nrd, nwr, wd, stray);
        checks++; if (rd !== 32'h0000005A || lat !== 2) begin errors++; $display("FAIL bload_s got %h lat=%0d want 0000005a lat=2", rd, lat); end
        run_txn(0, 1'b0, SZ_HALF, 1'b0, 32'd8, 32'h0, lat, rd, er, nrd, nwr, wd, stray);
        checks++; if (rd !== 32'hFFFFBE5A) begin errors++; $display("FAIL hload_s got %h want ffffbe5a", rd); end
        run_txn(1, 1'b0, SZ_HALF, 1'b1, 32'd8, 32'h0, lat, rd, er, nrd, nwr, wd, stray);
        checks++; if (rd !== 32'h0000BE5A) begin errors++; $display("FAIL hload_u got %h want 0000be5a", rd); end
    endtask

    task automatic test_fairness();
        int order[$];
        int who;
        logic [31:0] want;
        @(negedge Clk);
        drive(0, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'd8, 32'h0);
        drive(1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'd12, 32'h0);
        for (int c = 0; c < 60 && order.size() < 6; c++) begin
            @(negedge Clk);
            if (bus.rq0_ack || bus.rq1_ack) begin
                who  = bus.rq1_ack ? 1 : 0;
                want = exp_load(who ? 32'd12 : 32'd8, SZ_WORD, 1'b0);
                checks++;
                if ((bus.rq0_ack && bus.rq1_ack) || who !== (order.size() % 2))
                    begin errors++; $display("FAIL rr_order got ack0=%0b ack1=%0b want port %0d", bus.rq0_ack, bus.rq1_ack, order.size() % 2); end
                checks++;
                if (bus.rdata !== want) begin errors++; $display("FAIL rr_rdata got %h want %h", bus.rdata, want); end
                $display("txn tie grant -> port %0d rdata=%h", who, bus.rdata);
                order.push_back(who);
            end
        end
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        checks++;
        if (order.size() !== 6) begin errors++; $display("FAIL rr_count got %0d want 6", order.size()); end
        @(negedge Clk);
    endtask

    task automatic test_range();
        int lat, nrd, nwr, stray; logic [31:0] rd, wd; logic er;
        run_txn(0, 1'b0, SZ_WORD, 1'b0, 32'd62, 32'h0, lat, rd, er, nrd, nwr, wd, stray);
        checks++; if (er !== 1'b1 || lat !== 1) begin errors++; $display("FAIL range_err got err=%0b lat=%0d want 1/1", er, lat); end
        checks++; if (nrd !== 0 || nwr !== 0 || rd !== 32'h0) begin errors++; $display("FAIL range_noaccess got rd=%0d wr=%0d rdata=%h want 0/0/0", nrd, nwr, rd); end
        run_txn(1, 1'b1, SZ_BYTE, 1'b0, 32'd63, 32'h000000A5, lat, rd, er, nrd, nwr, wd, stray);
        ref_store(32'd63, SZ_BYTE, 32'h000000A5);
        checks++; if (er !== 1'b0 || lat !== 3) begin errors++; $display("FAIL top_bstore got err=%0b lat=%0d want 0/3", er, lat); end
        run_txn(0, 1'b0, SZ_BYTE, 1'b0, 32'd63, 32'h0, lat, rd, er, nrd, nwr, wd, stray);
        checks++; if (er !== 1'b0 || rd !== 32'hFFFFFFA5) begin errors++; $display("FAIL top_bload got %h err=%0b want ffffffa5/0", rd, er); end
        run_txn(1, 1'b0, SZ_HALF, 1'b1, 32'd63, 32'h0, lat, rd, er, nrd, nwr, wd, stray);
        checks++; if (er !== 1'b1 || nrd !== 0) begin errors++; $display("FAIL top_hload got err=%0b rd=%0d want 1/0", er, nrd); end
    endtask

    task automatic test_reset_mid_write();
        int first;
        logic seen;
        logic [31:0] want;
        // A tie now goes to port 0 and leaves the pointer on port 0.
        first = -1;
        @(negedge Clk);
        drive(0, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'd8, 32'h0);
        drive(1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'd12, 32'h0);
        for (int c = 0; c < 10 && first < 0; c++) begin
            @(negedge Clk);
            if (bus.rq0_ack) first = 0; else if (bus.rq1_ack) first = 1;
        end
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        checks++; if (first !== 0) begin errors++; $display("FAIL pre_tie got %0d want 0", first); end
        @(negedge Clk);
        // Word store, reset asserted while it is in WR.
        drive(0, 1'b1, 1'b1, SZ_WORD, 1'b0, 32'd16, 32'hCAFEF00D);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge Clk);
            if (bus.mem_MemWrite) seen = 1'b1;
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL mid_wr_reach got %0b want 1", seen); end
        Reset = 1'b1;
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        #1;
        checks++; if (bus.mem_MemWrite !== 1'b0 || bus.rq0_ack !== 1'b0) begin errors++; $display("FAIL mid_wr_drop got wr=%0b ack=%0b want 0/0", bus.mem_MemWrite, bus.rq0_ack); end
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        checks++; if (all_outs() !== 80'h0) begin errors++; $display("FAIL post_reset_idle got %h want 0", all_outs()); end
        $display("txn reset during WR of word store @16");
        // After reset port 0 wins a tie again; port 1 then reads the untouched @16.
        first = -1;
        seen  = 1'b0;
        drive(0, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'd8, 32'h0);
        drive(1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'd16, 32'h0);
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge Clk);
            if (bus.rq0_ack) begin
                if (first < 0) first = 0;
                drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
            end
            if (bus.rq1_ack) begin
                if (first < 0) first = 1;
                want = exp_load(32'd16, SZ_WORD, 1'b0);
                checks++; if (bus.rdata !== want) begin errors++; $display("FAIL dropped_store got %h want %h", bus.rdata, want); end
                drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
                seen = 1'b1;
            end
        end
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        checks++; if (first !== 0 || seen !== 1'b1) begin errors++; $display("FAIL post_reset_tie got first=%0d done=%0b want 0/1", first, seen); end
        @(negedge Clk);
    endtask

    task automatic test_unaligned();
        int lat, nrd, nwr, stray; logic [31:0] rd, wd; logic er;
        run_txn(1, 1'b1, SZ_WORD, 1'b0, 32'd12, 32'h11223344, lat, rd, er, nrd, nwr, wd, stray);
        ref_store(32'd12, SZ_WORD, 32'h11223344);
        run_txn(0, 1'b0, SZ_WORD, 1'b0, 32'd9, 32'h0, lat, rd, er, nrd, nwr, wd, stray);
`ifdef MEM_ARBITER_ALIGN_CHECK_EN
        checks++; if (er !== 1'b1 || nrd !== 0 || rd !== 32'h0) begin errors++; $display("FAIL unaligned_word got err=%0b rd=%0d rdata=%h want 1/0/0", er, nrd, rd); end
`else
        checks++; if (er !== 1'b0 || rd !== 32'h44DEADBE || lat !== 2) begin errors++; $display("FAIL unaligned_word got %h err=%0b lat=%0d want 44deadbe/0/2", rd, er, lat); end
`endif
    endtask

    task automatic test_random();
        int lat, nrd, nwr, stray; logic [31:0] rd, wd; logic er;
        int port; logic we, uns, rej, isw; logic [1:0] s; logic [31:0] addr, wdata, want_rd, want_wd;
        int want_lat;
        for (int t = 0; t < 60; t++) begin
            port  = int'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            s     = 2'($urandom_range(0, 3));
            uns   = 1'($urandom_range(0, 1));
            addr  = ($urandom_range(0, 7) == 0) ? $urandom_range(58, 70) : $urandom_range(0, 63);
            wdata = $urandom;
            rej   = exp_reject(addr, s);
            isw   = (nbytes_of(s) == 4);
            want_rd  = (we || rej) ? 32'h0 : exp_load(addr, s, uns);
            want_wd  = exp_wword(addr, s, wdata);
            want_lat = rej ? 1 : (!we ? 2 : (isw ? 2 : 3));
            run_txn(port, we, s, uns, addr, wdata, lat, rd, er, nrd, nwr, wd, stray);
            if (we && !rej) ref_store(addr, s, wdata);
            checks++; if (lat !== want_lat || er !== rej) begin errors++; $display("FAIL rnd%0d_resp got lat=%0d err=%0b want lat=%0d err=%0b", t, lat, er, want_lat, rej); end
            checks++; if (rd !== want_rd) begin errors++; $display("FAIL rnd%0d_rdata got %h want %h", t, rd, want_rd); end
            checks++; if (nrd !== int'(!rej && (!we || !isw)) || nwr !== int'(!rej && we) || stray !== 0)
                begin errors++; $display("FAIL rnd%0d_strobes got rd=%0d wr=%0d stray=%0d want rd=%0d wr=%0d stray=0", t, nrd, nwr, stray, int'(!rej && (!we || !isw)), int'(!rej && we)); end
            if (!rej && we) begin
                checks++; if (wd !== want_wd) begin errors++; $display("FAIL rnd%0d_wword got %h want %h", t, wd, want_wd); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < MEMB; i++) ref_mem[i] = 8'h00;
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        test_reset();
        test_word_store_load();
        test_subword();
        test_fairness();
        test_range();
        test_reset_mid_write();
        test_unaligned();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got no finish want finish before 400000");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester controller that shares the single-port, byte-addressed data RAM (64 bytes, little-endian, MemRead/MemWrite strobes, writes on posedge Clk) between the CPU load/store port (port 0) and the DMA/program-loader port (port 1).
- Arbitrates round-robin and sequences each transaction through the RAM.
- Adds byte/half/word access: sub-word loads are extracted and extended; sub-word stores use read-modify-write because the RAM always writes 4 bytes.

Parameters:
- MEM_BYTES, 64, RAM size in bytes; an access is out of range when addr + nbytes > MEM_BYTES.
- ADDR_W, 32, width of all address ports.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- rq0_req / rq1_req  in  1  request; held high until ack.
- rq0_we / rq1_we  in  1  1 = store, 0 = load.
- rq0_size / rq1_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- rq0_uns / rq1_uns  in  1  load zero-extend (1) or sign-extend (0).
- rq0_addr / rq1_addr  in  ADDR_W  byte address.
- rq0_wdata / rq1_wdata  in  32  store data, low-aligned.
- rq0_ack / rq1_ack  out  1  one-cycle completion pulse.
- rq0_err / rq1_err  out  1  pulses with ack when the access was rejected.
- rdata  out  32  load result, valid in the ack cycle.
- mem_address  out  ADDR_W  RAM address.
- mem_data_in  out  32  RAM write data.
- mem_MemRead  out  1  RAM read strobe.
- mem_MemWrite  out  1  RAM write strobe.
- mem_data_out  in  32  RAM read data.

Behaviour:
- Reset (async): state IDLE, rr pointer = 1 (port 0 wins the first tie), all outputs 0, latched request cleared. Reset mid-transaction drops it: no ack, MemWrite falls immediately.
- Transaction fields (we, size, uns, addr, wdata, granted id) are latched at acceptance. Requesters keep req high until ack and may drop req in the ack cycle. If req is still high in the cycle after ack, it is a new request.
- FSM states: IDLE, RD, RMW_RD, WR, RESP.
- IDLE:
  - If no req is high, stay in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the port that is not the rr pointer; the pointer is then set to the granted port.
  - Range check at acceptance: if out of range, go to RESP with err=1 and perform no RAM access.
  - Otherwise: load -> RD; word store -> WR; sub-word store -> RMW_RD.
- RD: mem_MemRead=1, mem_address=addr. mem_data_out is registered at the end of the cycle; next state RESP.
- RMW_RD: same as RD, but the registered word is merged:
  - byte store: {old[31:8], wdata[7:0]}
  - half store: {old[31:16], wdata[15:0]}
  - Next state WR.
- WR: mem_MemWrite=1, mem_address=addr, mem_data_in = wdata (word) or merged word. The RAM commits at the edge ending WR; next state RESP.
- RESP:
  - Granted ack=1 for one cycle; err as computed.
  - rdata: word = raw; half = ext(raw[15:0]); byte = ext(raw[7:0]). Store or err -> 0.
  - No acceptance in RESP; next state IDLE.
- Strobes, ack and err are 0 in every state not listed above. mem_address and mem_data_in are 0 in IDLE.
- Latency (acceptance edge -> ack cycle): load 2 cycles, word store 2, sub-word store 3, rejected access 1.
- Peak throughput: one transaction per 3 cycles (4 for sub-word stores).
- Fairness: with both ports continuously requesting, grants strictly alternate.
- A request arriving while busy waits; it is never lost.

Optional Feature:
- Macro: MEM_ARBITER_ALIGN_CHECK_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, is rejected like an out-of-range access (RESP, err=1, no RAM access).
- Undefined: unaligned accesses proceed normally (the RAM is byte-addressed); err comes only from the range check.

Decomposition:
- Package mem_arbiter_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - FSM state encoding (S_IDLE, S_RD, S_RMW_RD, S_WR, S_RESP)
  - nbytes-from-size function
- One natural sub-module, mem_arbiter_lane: combinational sub-word merge (store) and extract/extend (load), instantiated once.

Test Plan:
- Reset, then port 0 word store 0xDEADBEEF @8, then word load @8 -> MemWrite pulses 1 cycle with mem_data_in=0xDEADBEEF; load ack 2 cycles after acceptance with rdata=0xDEADBEEF.
- Port 1 byte store 0x5A @8 over 0xDEADBEEF -> RMW_RD then WR with mem_data_in=0xDEADBE5A; ack 3 cycles after acceptance. Then byte load @8 with uns=0 -> 0x0000005A; half load @8 with uns=0 -> 0xFFFFBE5A; half load @8 with uns=1 -> 0x0000BE5A.
- Both ports hold req for 6 transactions -> grant order 0,1,0,1,0,1; each ack goes only to the granted port.
- Word load @62 (MEM_BYTES=64) -> ack+err in the cycle after acceptance; no MemRead/MemWrite, rdata=0. Byte load @63 -> succeeds.
- Assert Reset during WR of a word store -> MemWrite drops immediately, no ack; after release, IDLE with all outputs 0 and port 0 wins the next tie.
- MEM_ARBITER_ALIGN_CHECK_EN defined, word load @9 -> err=1, no RAM access. Undefined -> rdata = bytes 9..12, no err.
